// File: rtl/sram_pixel_unpacker.sv
// Pairs 16-bit SRAM words into 24-bit RGB pixels (optional grayscale), queues them in a FIFO.
// Build option: PIXEL_BIT_REPLICATE_EN selects MSB replication instead of zero padding on channel widening.
module sram_pixel_unpacker #(
    parameter int unsigned OUT_W = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_sof,
    input  logic                     i_gray,
    input  logic [15:0]              i_word,
    input  logic                     i_word_valid,
    output logic                     o_word_ready,
    output logic                     o_pix_valid,
    input  logic                     i_pix_ready,
    output logic [OUT_W-1:0]         o_red,
    output logic [OUT_W-1:0]         o_green,
    output logic [OUT_W-1:0]         o_blue,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

    localparam logic [0:0] PH_WORD0 = 1'b0;
    localparam logic [0:0] PH_WORD1 = 1'b1;

    logic [0:0]    phase_q, phase_d;
    logic [12:0]   hold_q, hold_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [23:0]   mem_q [DEPTH];
    logic [23:0]   mem_d [DEPTH];

    logic          word_acc, push, pop;
    logic [7:0]    pix_r, pix_g, pix_b, gray_y;
    logic [9:0]    gray_sum;
    logic [23:0]   pix;
    logic [23:0]   head;
    logic          unused_word_bits;

    // Only the packed fields are kept; the remaining word bits carry no pixel data.
    assign unused_word_bits = ^{i_word[15], i_word[11:10], i_word[1:0]};

    assign o_word_ready = (phase_q == PH_WORD0) || (level_q < LVL_FULL);
    assign o_pix_valid  = (level_q != '0);
    assign o_level      = level_q;

    always_comb begin
        word_acc = i_word_valid && o_word_ready;
        push     = word_acc && (phase_q == PH_WORD1);
        pop      = o_pix_valid && i_pix_ready;

        pix_r    = hold_q[7:0];
        pix_g    = {hold_q[12:8], i_word[14:12]};
        pix_b    = i_word[9:2];
        gray_sum = {2'b00, pix_r} + {1'b0, pix_g, 1'b0} + {2'b00, pix_b};
        gray_y   = gray_sum[9:2];
        pix      = i_gray ? {gray_y, gray_y, gray_y} : {pix_r, pix_g, pix_b};

        phase_d  = phase_q;
        hold_d   = hold_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;

        // A start-of-frame discards any handshake completing in the same cycle.
        if (i_sof) begin
            phase_d  = PH_WORD0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (word_acc) begin
                if (phase_q == PH_WORD0) begin
                    hold_d  = {i_word[14:10], i_word[9:2]};
                    phase_d = PH_WORD1;
                end else begin
                    phase_d = PH_WORD0;
                end
            end
            if (push) begin
                mem_d[wr_ptr_q] = pix;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q  <= PH_WORD0;
            hold_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            phase_q  <= phase_d;
            hold_q   <= hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

    assign head = mem_q[rd_ptr_q];

    generate
        if (OUT_W == 8) begin : g_ext_none
            assign o_red   = head[23:16];
            assign o_green = head[15:8];
            assign o_blue  = head[7:0];
        end else begin : g_ext_wide
`ifdef PIXEL_BIT_REPLICATE_EN
            assign o_red   = {head[23:16], head[23 -: OUT_W-8]};
            assign o_green = {head[15:8],  head[15 -: OUT_W-8]};
            assign o_blue  = {head[7:0],   head[7  -: OUT_W-8]};
`else
            assign o_red   = {head[23:16], {(OUT_W-8){1'b0}}};
            assign o_green = {head[15:8],  {(OUT_W-8){1'b0}}};
            assign o_blue  = {head[7:0],   {(OUT_W-8){1'b0}}};
`endif
        end
    endgenerate

endmodule

// File: tb/tb_sram_pixel_unpacker.sv
// Self-checking bench for sram_pixel_unpacker: vector table, directed corner sequences, random vs queue model.
module tb_sram_pixel_unpacker;

    localparam int OUT_W = 10;
    localparam int DEPTH = 8;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n = 1'b1;
    logic                   i_sof = 1'b0;
    logic                   i_gray = 1'b0;
    logic [15:0]            i_word = '0;
    logic                   i_word_valid = 1'b0;
    logic                   o_word_ready;
    logic                   o_pix_valid;
    logic                   i_pix_ready = 1'b0;
    logic [OUT_W-1:0]       o_red, o_green, o_blue;
    logic [$clog2(DEPTH):0] o_level;

    int checks = 0;
    int errors = 0;

    sram_pixel_unpacker #(.OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_sof        (i_sof),
        .i_gray       (i_gray),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .o_word_ready (o_word_ready),
        .o_pix_valid  (o_pix_valid),
        .i_pix_ready  (i_pix_ready),
        .o_red        (o_red),
        .o_green      (o_green),
        .o_blue       (o_blue),
        .o_level      (o_level)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        bit          gray;
        int          er;
        int          eg;
        int          eb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int ext(input int c);
`ifdef PIXEL_BIT_REPLICATE_EN
        return (c << (OUT_W - 8)) | (c >> (16 - OUT_W));
`else
        return c << (OUT_W - 8);
`endif
    endfunction

    // Pixel from the packing rules, expressed with shifts and masks on whole words.
    function automatic int pack_pix(input logic [15:0] w0, input logic [15:0] w1, input bit gray);
        int r, g, b, y;
        r = (int'(w0) >> 2) & 255;
        g = ((int'(w0) >> 10) & 31) * 8 + ((int'(w1) >> 12) & 7);
        b = (int'(w1) >> 2) & 255;
        if (gray) begin
            y = (r + 2 * g + b) / 4;
            return (y << 16) | (y << 8) | y;
        end
        return (r << 16) | (g << 8) | b;
    endfunction

    task automatic chk_head(input string name, input int pix);
        chk({name, "_valid"}, o_pix_valid, 1);
        chk({name, "_red"},   o_red,   ext((pix >> 16) & 255));
        chk({name, "_green"}, o_green, ext((pix >> 8) & 255));
        chk({name, "_blue"},  o_blue,  ext(pix & 255));
    endtask

    task automatic send_word(input logic [15:0] w, input bit gray);
        int t;
        t = 0;
        i_word = w;
        i_gray = gray;
        i_word_valid = 1'b1;
        while (!o_word_ready && t < 50) begin
            @(posedge i_clk); #1;
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL word_ready_timeout: got ready=0 expected ready=1 within 50 cycles");
        end
        @(posedge i_clk); #1;
        i_word_valid = 1'b0;
    endtask

    task automatic pop_expect(input string name, input int pix);
        chk_head(name, pix);
        i_pix_ready = 1'b1;
        @(posedge i_clk); #1;
        i_pix_ready = 1'b0;
    endtask

    task automatic do_reset();
        i_sof = 0; i_word_valid = 0; i_pix_ready = 0; i_gray = 0;
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    vec_t        vecs[8];
    logic [15:0] w[18];
    int          q[$];
    int          lvl_seq[6];
    bit          mph;
    logic [15:0] mhold;
    bit          exp_rdy, acc, popm;

    initial begin
        vecs[0] = '{16'h7FFC, 16'h7000, 1'b0, 8'hFF, 8'hFF, 8'h00};
        vecs[1] = '{16'h7FFC, 16'h7000, 1'b1, 8'hBF, 8'hBF, 8'hBF};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{16'h8003, 16'h8C03, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{16'h0004, 16'h1008, 1'b0, 8'h01, 8'h01, 8'h02};
        vecs[5] = '{16'h0004, 16'h1008, 1'b1, 8'h01, 8'h01, 8'h01};
        vecs[6] = '{16'h0400, 16'h03FC, 1'b0, 8'h00, 8'h08, 8'hFF};
        vecs[7] = '{16'h0400, 16'h03FC, 1'b1, 8'h43, 8'h43, 8'h43};
        lvl_seq = '{3, 3, 2, 2, 1, 1};

        // Asynchronous reset asserted before the first clock edge.
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_valid", o_pix_valid, 0);
        chk("rst_ready", o_word_ready, 1);
        chk("rst_level", o_level, 0);
        chk("rst_red", o_red, 0);
        chk("rst_green", o_green, 0);
        chk("rst_blue", o_blue, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // Table vectors; word0 carries the opposite gray flag to show it is sampled at push.
        for (int i = 0; i < 8; i++) begin
            send_word(vecs[i].w0, !vecs[i].gray);
            send_word(vecs[i].w1, vecs[i].gray);
            chk("vec_level", o_level, 1);
            chk("vec_red",   o_red,   ext(vecs[i].er));
            chk("vec_green", o_green, ext(vecs[i].eg));
            chk("vec_blue",  o_blue,  ext(vecs[i].eb));
            pop_expect("vec_pop", (vecs[i].er << 16) | (vecs[i].eg << 8) | vecs[i].eb);
            chk("vec_level_after_pop", o_level, 0);
        end
        send_word(16'h7FFC, 1'b0);
        send_word(16'h7000, 1'b0);
`ifdef PIXEL_BIT_REPLICATE_EN
        chk("basic_red_lit", o_red, 10'h3FF);
`else
        chk("basic_red_lit", o_red, 10'h3FC);
`endif
        pop_expect("basic_pop", pack_pix(16'h7FFC, 16'h7000, 1'b0));

        // Full FIFO and backpressure.
        do_reset();
        for (int k = 0; k < 18; k++) w[k] = 16'($urandom);
        for (int k = 0; k < 16; k++) send_word(w[k], 1'b0);
        chk("full_level", o_level, DEPTH);
        chk("full_ready_phase0", o_word_ready, 1);
        send_word(w[16], 1'b0);
        chk("full_level_after_w0", o_level, DEPTH);
        i_word = w[17];
        i_word_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("full_ready_low", o_word_ready, 0);
            @(posedge i_clk); #1;
            chk("full_level_hold", o_level, DEPTH);
        end
        chk_head("full_head0", pack_pix(w[0], w[1], 1'b0));
        i_pix_ready = 1'b1;
        @(posedge i_clk); #1;
        i_pix_ready = 1'b0;
        chk("full_level_after_pop", o_level, DEPTH - 1);
        chk("full_ready_after_pop", o_word_ready, 1);
        @(posedge i_clk); #1;
        i_word_valid = 1'b0;
        chk("full_level_refill", o_level, DEPTH);
        for (int k = 1; k < 9; k++) pop_expect("full_drain", pack_pix(w[2*k], w[2*k+1], 1'b0));
        chk("full_drained", o_level, 0);

        // Simultaneous push and pop starting from level 4.
        do_reset();
        q.delete();
        for (int k = 0; k < 8; k++) w[k] = 16'($urandom);
        for (int k = 0; k < 4; k++) begin
            send_word(w[2*k], 1'b0);
            send_word(w[2*k+1], 1'b0);
            q.push_back(pack_pix(w[2*k], w[2*k+1], 1'b0));
        end
        chk("pp_level4", o_level, 4);
        for (int k = 0; k < 6; k++) w[8+k] = 16'($urandom);
        i_pix_ready = 1'b1;
        i_word_valid = 1'b1;
        i_gray = 1'b0;
        for (int c = 0; c < 6; c++) begin
            i_word = w[8+c];
            chk("pp_ready", o_word_ready, 1);
            chk_head("pp_head", q.pop_front());
            @(posedge i_clk); #1;
            if (c % 2 == 1) q.push_back(pack_pix(w[8+c-1], w[8+c], 1'b0));
            chk("pp_level", o_level, lvl_seq[c]);
        end
        i_word_valid = 1'b0;
        i_pix_ready = 1'b0;
        while (q.size() > 0) pop_expect("pp_drain", q.pop_front());
        chk("pp_empty", o_pix_valid, 0);

        // Flush after a lone word0, then with three pixels queued and handshakes in flight.
        do_reset();
        send_word(16'h1234, 1'b0);
        i_sof = 1'b1;
        @(posedge i_clk); #1;
        i_sof = 1'b0;
        chk("sof1_level", o_level, 0);
        chk("sof1_valid", o_pix_valid, 0);
        send_word(16'h5A5C, 1'b0);
        send_word(16'h6F30, 1'b0);
        chk("sof1_level_new", o_level, 1);
        chk_head("sof1_fresh", pack_pix(16'h5A5C, 16'h6F30, 1'b0));
        send_word(16'h1111, 1'b0); send_word(16'h2222, 1'b0);
        send_word(16'h3333, 1'b0); send_word(16'h4444, 1'b0);
        chk("sof2_level3", o_level, 3);
        send_word(16'h7777, 1'b0);
        i_sof = 1'b1; i_word = 16'h0FF0; i_word_valid = 1'b1; i_pix_ready = 1'b1;
        @(posedge i_clk); #1;
        i_sof = 1'b0; i_word_valid = 1'b0; i_pix_ready = 1'b0;
        chk("sof2_level", o_level, 0);
        chk("sof2_valid", o_pix_valid, 0);
        chk("sof2_ready", o_word_ready, 1);
        send_word(16'h2468, 1'b1);
        send_word(16'h7BDC, 1'b1);
        chk("sof2_level_new", o_level, 1);
        pop_expect("sof2_fresh", pack_pix(16'h2468, 16'h7BDC, 1'b1));

        // Asynchronous reset mid-operation with five pixels queued and a word0 held.
        for (int k = 0; k < 5; k++) begin
            send_word(16'h7FFC, 1'b0);
            send_word(16'h7000, 1'b0);
        end
        send_word(16'h1357, 1'b0);
        chk("mid_level5", o_level, 5);
        #3 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_pix_valid, 0);
        chk("mid_rst_ready", o_word_ready, 1);
        chk("mid_rst_level", o_level, 0);
        chk("mid_rst_red", o_red, 0);
        chk("mid_rst_green", o_green, 0);
        chk("mid_rst_blue", o_blue, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        send_word(16'h4C48, 1'b0);
        send_word(16'h3A9C, 1'b0);
        chk("mid_after_level", o_level, 1);
        pop_expect("mid_after_pix", pack_pix(16'h4C48, 16'h3A9C, 1'b0));

        // Random traffic against a queue model.
        do_reset();
        q.delete();
        mph = 1'b0;
        mhold = '0;
        for (int n = 0; n < 3000; n++) begin
            exp_rdy = !mph || (q.size() < DEPTH);
            chk("rnd_valid", o_pix_valid, q.size() > 0);
            chk("rnd_level", o_level, q.size());
            chk("rnd_ready", o_word_ready, exp_rdy);
            if (q.size() > 0) begin
                chk("rnd_red",   o_red,   ext((q[0] >> 16) & 255));
                chk("rnd_green", o_green, ext((q[0] >> 8) & 255));
                chk("rnd_blue",  o_blue,  ext(q[0] & 255));
            end
            i_sof        = ($urandom_range(63) == 0);
            i_word_valid = ($urandom_range(3) != 0);
            i_word       = 16'($urandom);
            i_gray       = 1'($urandom_range(1));
            i_pix_ready  = ($urandom_range(2) != 0);
            acc  = i_word_valid && exp_rdy;
            popm = i_pix_ready && (q.size() > 0);
            @(posedge i_clk); #1;
            if (i_sof) begin
                q.delete();
                mph = 1'b0;
            end else begin
                if (popm) void'(q.pop_front());
                if (acc) begin
                    if (!mph) mhold = i_word;
                    else q.push_back(pack_pix(mhold, i_word, i_gray));
                    mph = !mph;
                end
            end
        end
        i_sof = 0; i_word_valid = 0; i_pix_ready = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
